// File: rtl/rr_stream_arb.sv
// rr_stream_arb: round-robin arbiter over CHANNELS valid/ready input streams
// feeding a single registered output slot (EMPTY/FULL). The slot accepts a new
// word in the same cycle it hands the held one downstream, so throughput is
// one word per cycle.
module rr_stream_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS-1:0]       i_in_valid,
    input  logic [CHANNELS*WIDTH-1:0] i_in_bus,
    output logic [CHANNELS-1:0]       o_in_ready,
    output logic [CHANNELS-1:0]       o_grant,
    output logic [SELW-1:0]           o_sel,
    output logic                      o_out_valid,
    output logic [WIDTH-1:0]          o_out_data,
    input  logic                      i_out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SELW-1:0]     r_ptr;
    logic [WIDTH-1:0]    r_data;

    logic                w_open;
    logic                w_in_xfer;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_sel;
    logic [SELW-1:0]     w_ptr_nxt;
    logic [WIDTH-1:0]    w_word;

    // Reset gates the arbiter directly so nothing is granted while rst_n is low.
    assign w_open    = i_rst_n && ((r_state == EMPTY) || i_out_ready);
    assign w_in_xfer = |w_grant;
    assign w_ptr_nxt = (w_sel == SELW'(CHANNELS - 1)) ? '0 : w_sel + SELW'(1);

    // Scan requests upward from r_ptr with wrap; first set bit wins.
    always_comb begin
        int  idx;
        logic found;
        w_grant = '0;
        w_sel   = '0;
        found   = 1'b0;
        idx     = 0;
        if (w_open) begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!found && i_in_valid[idx]) begin
                    found        = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_sel        = SELW'(idx);
                end
            end
        end
    end

    // Pick the granted channel's slice; ready/grant never look at in_bus.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) w_word = i_in_bus[i*WIDTH +: WIDTH];
        end
    end

    // Output-slot state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= EMPTY;
        else          r_state <= w_state_nxt;
    end

    // Output-slot next state: fill on accept, drain when handed off with no refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_in_xfer) w_state_nxt = FULL;
            FULL:    if (i_out_ready && !w_in_xfer) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Output-slot outputs and arbiter handshakes.
    always_comb begin
        o_out_valid = (r_state == FULL);
        o_out_data  = r_data;
        o_grant     = w_grant;
        o_in_ready  = w_grant;
        o_sel       = w_sel;
    end

    // Data slot and round-robin pointer advance only on an accepted input word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_ptr  <= '0;
        end else if (w_in_xfer) begin
            r_data <= w_word;
            r_ptr  <= w_ptr_nxt;
        end
    end

endmodule

// File: doc/rr_stream_arb.md
RR_STREAM_ARB -- requirements
Module: rr_stream_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of each channel and of the output word.
REQ-002 Parameter CHANNELS, default 4, number of input channels (>=2).
REQ-003 SELW = clogb2(CHANNELS), minimum 1, is the width of sel.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  CHANNELS  per-channel request; bit i = channel i has a word.
REQ-007 in_bus  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  CHANNELS  per-channel accept, combinational, at most one bit set.
REQ-009 grant  output  CHANNELS  one-hot granted channel this cycle; equals in_ready.
REQ-010 sel  output  SELW  binary index of granted channel; drives downstream mux select.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered output word.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 Transfer on a channel i SHALL occur in a cycle where in_valid[i] && in_ready[i]; output transfer occurs where out_valid && out_ready.
REQ-015 Output stage SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 Block SHALL be able to accept ("open") in a cycle iff state is EMPTY, or FULL with out_ready=1.
REQ-017 When open and in_valid != 0, grant SHALL select the first set in_valid bit scanning upward from ptr, wrapping from CHANNELS-1 to 0.
REQ-018 When not open, or in_valid == 0, grant, in_ready SHALL be all-zero and sel SHALL be 0.
REQ-019 sel SHALL equal the index of the set grant bit whenever grant != 0.
REQ-020 On an input transfer from channel i, out_data SHALL load in_bus slice i and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-021 On an output transfer with no simultaneous input transfer, out_valid SHALL be 0 next cycle.
REQ-022 Simultaneous output and input transfer SHALL replace out_data with the new word, out_valid stays 1; sustained throughput one word per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-024 Round-robin pointer ptr (SELW bits) SHALL update to (i+1) mod CHANNELS only on an input transfer from channel i; otherwise hold.
REQ-025 Wrap: granting channel CHANNELS-1 SHALL set ptr to 0; non-power-of-two CHANNELS never produces ptr >= CHANNELS.
REQ-026 A channel whose in_valid drops before grant SHALL not be granted; no request is latched internally.
REQ-027 in_ready SHALL never depend on in_bus.

Reset
REQ-028 While rst_n=0 at a clock edge: out_valid=0, out_data=0, ptr=0 next cycle.
REQ-029 While rst_n=0, in_ready, grant and sel SHALL be 0 regardless of inputs.
REQ-030 Reset mid-operation SHALL discard any held output word; no transfer is reported during reset.
REQ-031 First grant after reset SHALL start scanning from channel 0.

Verification
REQ-032 Reset then in_valid=4'b1111, out_ready=1, channel i data = 8'hA0+i -> grants 0,1,2,3,0 on consecutive cycles; out_data A0,A1,A2,A3,A0 each one cycle later.
REQ-033 in_valid=4'b1010, out_ready=1 -> grants alternate channel 1, 3, 1, 3; sel 1,3,1,3; channels 0 and 2 never ready.
REQ-034 Load word 8'h5C, hold out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data stays 5C, out_valid 1, in_ready 0 throughout; release -> 5C transfers, next grant taken same cycle.
REQ-035 Last grant channel 3 (ptr=0), then in_valid=4'b1000 only -> channel 3 granted again; ptr returns to 0.
REQ-036 Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0; after release with in_valid=4'b0110 first grant is channel 1.
REQ-037 CHANNELS=3, WIDTH=16, all requesting -> grants 0,1,2,0; sel never 3.
